// File: rtl/seven_seg_scanner_if.sv
// seven_seg_scanner_if: Avalon-MM register bus between the host and the scanner
interface seven_seg_scanner_if;
   logic [1:0]  address;
   logic        chipselect;
   logic        write_n;
   logic [31:0] writedata;
   logic [31:0] readdata;
   modport master (output address, chipselect, write_n, writedata, input readdata);
   modport slave  (input address, chipselect, write_n, writedata, output readdata);
endinterface

// File: rtl/seven_seg_scanner.sv
// seven_seg_scanner: eight-digit multiplexed common-anode scan controller with guard,
// PWM brightness and leading-zero blanking
module seven_seg_scanner #(
   parameter logic [15:0] DEFAULT_DIV = 16'd49999,
   parameter int unsigned GUARD_CYC   = 2
) (
   input  logic                clk,
   input  logic                reset_n,
   seven_seg_scanner_if.slave  bus,
   input  logic [31:0]         data_in,
   output logic [6:0]          seg_n,
   output logic                dp_n,
   output logic [7:0]          dig_n
);
   typedef enum logic [1:0] {S_OFF = 2'd0, S_DRIVE = 2'd1, S_GUARD = 2'd2} state_t;
   localparam logic [15:0] GUARD_LAST = 16'(GUARD_CYC - 1);

   state_t      r_state, w_state_nx;
   logic        r_en, r_lzb;
   logic [2:0]  r_last;
   logic [7:0]  r_dpmask;
   logic [15:0] r_div;
   logic [3:0]  r_duty, r_pwm;
   logic [15:0] r_cnt, w_cnt_nx;
   logic [2:0]  r_idx, w_idx_nx;
   logic [31:0] r_shadow, w_shadow_nx;
   logic [6:0]  r_seg, w_seg, w_hex;
   logic        r_dp, w_dp;
   logic [7:0]  r_dig, w_dig;
   logic [3:0]  w_nib;
   logic        w_wr, w_drive, w_blank;
   logic        w_unused;

   assign w_wr     = bus.chipselect && !bus.write_n;
   assign w_unused = &{1'b0, bus.writedata[31:16]};

   always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) begin
         {r_dpmask, r_last, r_lzb, r_en} <= {8'h00, 3'd7, 1'b0, 1'b1};
         r_div  <= DEFAULT_DIV;
         r_duty <= 4'hF;
      end else if (w_wr) begin
         if (bus.address == 2'd0) {r_dpmask, r_last, r_lzb, r_en} <= {bus.writedata[15:8], bus.writedata[6:4], bus.writedata[1:0]};
         if (bus.address == 2'd1) r_div <= bus.writedata[15:0];
         if (bus.address == 2'd2) r_duty <= bus.writedata[3:0];
      end

   assign bus.readdata = bus.address == 2'd0 ? {16'd0, r_dpmask, 1'b0, r_last, 2'b00, r_lzb, r_en}
                       : bus.address == 2'd1 ? {16'd0, r_div}
                       : bus.address == 2'd2 ? {28'd0, r_duty}
                       : {26'd0, r_state, 1'b0, r_idx};

   // cnt times both the DRIVE dwell and the GUARD interval
   always_comb begin
      w_state_nx  = r_state;
      w_cnt_nx    = r_cnt;
      w_idx_nx    = r_idx;
      w_shadow_nx = r_shadow;
      if (!r_en) w_state_nx = S_OFF;
      else case (r_state)
         S_OFF: begin
            w_state_nx  = S_DRIVE;
            w_shadow_nx = data_in;
            w_idx_nx    = 3'd0;
            w_cnt_nx    = 16'd0;
         end
         S_DRIVE: begin
            w_cnt_nx   = r_cnt == r_div ? 16'd0 : r_cnt + 16'd1;
            w_state_nx = r_cnt == r_div ? S_GUARD : S_DRIVE;
         end
         S_GUARD:
            if (r_cnt == GUARD_LAST) begin
               w_cnt_nx    = 16'd0;
               w_state_nx  = S_DRIVE;
               w_idx_nx    = r_idx >= r_last ? 3'd0 : r_idx + 3'd1;
               w_shadow_nx = r_idx >= r_last ? data_in : r_shadow;
            end else w_cnt_nx = r_cnt + 16'd1;
         default: w_state_nx = S_OFF;
      endcase
   end

   assign w_nib = r_shadow[{r_idx, 2'b00} +: 4];

   always_comb
      case (w_nib)
         4'h0: w_hex = 7'h40;
         4'h1: w_hex = 7'h79;
         4'h2: w_hex = 7'h24;
         4'h3: w_hex = 7'h30;
         4'h4: w_hex = 7'h19;
         4'h5: w_hex = 7'h12;
         4'h6: w_hex = 7'h02;
         4'h7: w_hex = 7'h78;
         4'h8: w_hex = 7'h00;
         4'h9: w_hex = 7'h10;
         4'hA: w_hex = 7'h08;
         4'hB: w_hex = 7'h03;
         4'hC: w_hex = 7'h46;
         4'hD: w_hex = 7'h21;
         4'hE: w_hex = 7'h06;
         default: w_hex = 7'h0E;
      endcase

   // blank when every nibble from idx up to LAST is zero; digit 0 always shows
   always_comb begin
      w_blank = r_lzb && (r_idx != 3'd0);
      for (int i = 0; i < 8; i++)
         if (3'(i) >= r_idx && 3'(i) <= r_last && r_shadow[4*i +: 4] != 4'd0) w_blank = 1'b0;
   end

   assign w_drive = r_state == S_DRIVE;
   assign w_seg   = (!w_drive || w_blank) ? 7'h7F : w_hex;
   assign w_dp    = !w_drive || !r_dpmask[r_idx];
   assign w_dig   = (w_drive && r_pwm <= r_duty) ? ~(8'd1 << r_idx) : 8'hFF;

   always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) begin
         r_state  <= S_OFF;
         r_cnt    <= 16'd0;
         r_idx    <= 3'd0;
         r_shadow <= 32'd0;
         r_pwm    <= 4'd0;
         r_seg    <= 7'h7F;
         r_dp     <= 1'b1;
         r_dig    <= 8'hFF;
      end else begin
         r_state  <= w_state_nx;
         r_cnt    <= w_cnt_nx;
         r_idx    <= w_idx_nx;
         r_shadow <= w_shadow_nx;
         r_pwm    <= r_pwm + 4'd1;
         r_seg    <= w_seg;
         r_dp     <= w_dp;
         r_dig    <= w_dig;
      end

   assign seg_n = r_seg;
   assign dp_n  = r_dp;
   assign dig_n = r_dig;
endmodule

// File: tb/tb_seven_seg_scanner.sv
// tb_seven_seg_scanner: directed checks of scan timing, decode, blanking, snapshot,
// PWM, LAST/DP, disable and asynchronous reset
module tb_seven_seg_scanner;
   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic [31:0] data_in;
   logic [6:0]  seg_n;
   logic        dp_n;
   logic [7:0]  dig_n;
   int          total = 0;
   int          bad = 0;
   logic [7:0]  c_dig [96];
   logic [6:0]  c_seg [96];
   logic        c_dp  [96];
   localparam logic [6:0] HEX [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                       7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

   seven_seg_scanner_if bus ();

   seven_seg_scanner #(.DEFAULT_DIV(16'd3), .GUARD_CYC(2)) dut (
      .clk(clk), .reset_n(reset_n), .bus(bus.slave), .data_in(data_in),
      .seg_n(seg_n), .dp_n(dp_n), .dig_n(dig_n));

   always #5 clk = ~clk;

   task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
      bus.address = a;
      bus.writedata = d;
      bus.chipselect = 1'b1;
      bus.write_n = 1'b0;
      @(posedge clk);
      #1;
      bus.chipselect = 1'b0;
      bus.write_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
      bus.address = a;
      #1;
      d = bus.readdata;
   endtask

   task automatic wait_dig(input logic [7:0] t, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 600 && !ok; i++)
         if (dig_n === t) ok = 1'b1; else @(negedge clk);
   endtask

   task automatic wait_status(input logic [31:0] t, output bit ok);
      ok = 1'b0;
      bus.address = 2'd3;
      #1;
      for (int i = 0; i < 600 && !ok; i++)
         if (bus.readdata === t) ok = 1'b1; else begin @(negedge clk); #1; end
   endtask

   task automatic capture(input int n, input int chg_at, input logic [31:0] chg_val);
      for (int k = 0; k < n; k++) begin
         if (k == chg_at) data_in = chg_val;
         c_dig[k] = dig_n;
         c_seg[k] = seg_n;
         c_dp[k]  = dp_n;
         @(negedge clk);
      end
   endtask

   task automatic sync_frame(input string nm);
      bit ok1, ok2;
      wait_dig(8'h7F, ok1);
      wait_dig(8'hFE, ok2);
      total++;
      if (!(ok1 && ok2)) begin bad++; $display("FAIL %s sync: dig_n=%h want 7f then fe", nm, dig_n); end
   endtask

   task automatic test_reset;
      logic [31:0] d;
      data_in = 32'h01234567;
      bus.address = 2'd0;
      bus.chipselect = 1'b0;
      bus.write_n = 1'b1;
      bus.writedata = 32'd0;
      reset_n = 1'b0;
      repeat (2) @(negedge clk);
      total++;
      if ({seg_n, dp_n, dig_n} !== {7'h7F, 1'b1, 8'hFF}) begin
         bad++; $display("FAIL reset outputs: seg=%h dp=%b dig=%h want 7f 1 ff", seg_n, dp_n, dig_n);
      end
      bus_read(2'd0, d); total++;
      if (d !== 32'h71) begin bad++; $display("FAIL reset ctrl: %h want 71", d); end
      bus_read(2'd1, d); total++;
      if (d !== 32'h3) begin bad++; $display("FAIL reset div: %h want 3", d); end
      bus_read(2'd2, d); total++;
      if (d !== 32'hF) begin bad++; $display("FAIL reset duty: %h want f", d); end
      bus_read(2'd3, d); total++;
      if (d !== 32'h0) begin bad++; $display("FAIL reset status: %h want 0", d); end
   endtask

   task automatic test_period;
      logic [31:0] d;
      logic [31:0] w;
      logic [7:0]  e;
      w = 32'h01234567;
      @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);
      total++;
      if (dig_n !== 8'hFF) begin bad++; $display("FAIL first edge dig: %h want ff", dig_n); end
      bus_read(2'd3, d); total++;
      if (d !== 32'h10) begin bad++; $display("FAIL first edge status: %h want 10", d); end
      @(negedge clk);
      total++;
      if ({dig_n, seg_n} !== {8'hFE, 7'h78}) begin
         bad++; $display("FAIL second edge: dig=%h seg=%h want fe 78", dig_n, seg_n);
      end
      capture(49, -1, 32'd0);
      for (int k = 0; k < 48; k++) begin
         e = (k % 6 < 4) ? ~(8'd1 << (k / 6)) : 8'hFF;
         total++;
         if (c_dig[k] !== e) begin bad++; $display("FAIL period dig k=%0d: %h want %h", k, c_dig[k], e); end
         if (k % 6 < 4) begin
            total++;
            if (c_seg[k] !== HEX[4'(w >> (4 * (k / 6)))]) begin
               bad++; $display("FAIL period seg k=%0d: %h want %h", k, c_seg[k], HEX[4'(w >> (4 * (k / 6)))]);
            end
         end
      end
      total++;
      if (c_dig[48] !== 8'hFE) begin bad++; $display("FAIL frame wrap dig: %h want fe", c_dig[48]); end
   endtask

   task automatic test_regs;
      logic [31:0] d;
      bus_write(2'd1, 32'hFFFF0003);
      bus_read(2'd1, d); total++;
      if (d !== 32'h3) begin bad++; $display("FAIL div readback: %h want 3", d); end
      bus_write(2'd0, 32'hFFFFFFF3);
      bus_read(2'd0, d); total++;
      if (d !== 32'hFF73) begin bad++; $display("FAIL ctrl readback: %h want ff73", d); end
      bus_write(2'd2, 32'hFFFFFFF5);
      bus_read(2'd2, d); total++;
      if (d !== 32'h5) begin bad++; $display("FAIL duty readback: %h want 5", d); end
      bus_write(2'd0, 32'h71);
      bus_write(2'd2, 32'hF);
      bus_write(2'd3, 32'hFFFFFFFF);
      bus_read(2'd0, d); total++;
      if (d !== 32'h71) begin bad++; $display("FAIL status write leak ctrl: %h want 71", d); end
      bus_read(2'd2, d); total++;
      if (d !== 32'hF) begin bad++; $display("FAIL status write leak duty: %h want f", d); end
   endtask

   task automatic test_lzb;
      logic [6:0] e;
      data_in = 32'h000000A0;
      bus_write(2'd0, 32'h73);
      sync_frame("lzb");
      capture(48, -1, 32'd0);
      for (int k = 0; k < 48; k++)
         if (k % 6 < 4) begin
            e = (k / 6 == 0) ? 7'h40 : (k / 6 == 1) ? 7'h08 : 7'h7F;
            total++;
            if (c_seg[k] !== e) begin bad++; $display("FAIL lzb seg k=%0d: %h want %h", k, c_seg[k], e); end
         end
      data_in = 32'd0;
      sync_frame("lzb0");
      capture(12, -1, 32'd0);
      total++;
      if (c_seg[0] !== 7'h40) begin bad++; $display("FAIL lzb zero digit0: %h want 40", c_seg[0]); end
      total++;
      if (c_seg[6] !== 7'h7F) begin bad++; $display("FAIL lzb zero digit1: %h want 7f", c_seg[6]); end
   endtask

   task automatic test_snapshot;
      bus_write(2'd0, 32'h71);
      data_in = 32'h01234567;
      sync_frame("snap");
      capture(96, 19, 32'h89ABCDEF);
      total++;
      if (c_seg[18] !== 7'h19) begin bad++; $display("FAIL snap digit3: %h want 19", c_seg[18]); end
      total++;
      if (c_seg[24] !== 7'h30) begin bad++; $display("FAIL snap digit4: %h want 30", c_seg[24]); end
      total++;
      if (c_seg[30] !== 7'h24) begin bad++; $display("FAIL snap digit5: %h want 24", c_seg[30]); end
      total++;
      if (c_seg[36] !== 7'h79) begin bad++; $display("FAIL snap digit6: %h want 79", c_seg[36]); end
      total++;
      if (c_seg[42] !== 7'h40) begin bad++; $display("FAIL snap digit7: %h want 40", c_seg[42]); end
      total++;
      if ({c_dig[48], c_seg[48]} !== {8'hFE, 7'h0E}) begin
         bad++; $display("FAIL snap new digit0: dig=%h seg=%h want fe 0e", c_dig[48], c_seg[48]);
      end
      total++;
      if (c_seg[66] !== 7'h46) begin bad++; $display("FAIL snap new digit3: %h want 46", c_seg[66]); end
      total++;
      if ({c_dig[90], c_seg[90]} !== {8'h7F, 7'h00}) begin
         bad++; $display("FAIL snap new digit7: dig=%h seg=%h want 7f 00", c_dig[90], c_seg[90]);
      end
   endtask

   task automatic test_last_dp;
      bit ok;
      logic [7:0] e;
      logic e_dp;
      bus_write(2'd0, 32'h0471);
      wait_dig(8'hBF, ok);
      total++;
      if (!ok) begin bad++; $display("FAIL last wait digit6: dig=%h want bf", dig_n); end
      bus_write(2'd0, 32'h0431);
      for (int i = 0; i < 40 && (dig_n === 8'hBF || dig_n === 8'hFF); i++) @(negedge clk);
      total++;
      if (dig_n !== 8'hFE) begin bad++; $display("FAIL last next digit: %h want fe", dig_n); end
      capture(48, -1, 32'd0);
      for (int k = 0; k < 48; k++) begin
         e = (k % 6 < 4) ? ~(8'd1 << ((k % 24) / 6)) : 8'hFF;
         total++;
         if (c_dig[k] !== e) begin bad++; $display("FAIL last dig k=%0d: %h want %h", k, c_dig[k], e); end
         if (k % 6 < 4) begin
            e_dp = ((k % 24) / 6 == 2) ? 1'b0 : 1'b1;
            total++;
            if (c_dp[k] !== e_dp) begin bad++; $display("FAIL dp k=%0d: %b want %b", k, c_dp[k], e_dp); end
         end
      end
   endtask

   task automatic test_pwm;
      int lows, shape;
      bus_write(2'd0, 32'h71);
      bus_write(2'd1, 32'd31);
      bus_write(2'd2, 32'd0);
      repeat (300) @(negedge clk);
      lows = 0;
      shape = 0;
      for (int k = 0; k < 272; k++) begin
         if (dig_n !== 8'hFF) begin
            lows++;
            if ($countones(~dig_n) != 1) shape++;
         end
         @(negedge clk);
      end
      total++;
      if (lows !== 16) begin bad++; $display("FAIL pwm duty0 on-clocks: %0d want 16", lows); end
      total++;
      if (shape !== 0) begin bad++; $display("FAIL pwm one-hot violations: %0d want 0", shape); end
      bus_write(2'd2, 32'd15);
      repeat (40) @(negedge clk);
      lows = 0;
      for (int k = 0; k < 272; k++) begin
         if (dig_n !== 8'hFF) lows++;
         @(negedge clk);
      end
      total++;
      if (lows !== 256) begin bad++; $display("FAIL pwm duty15 on-clocks: %0d want 256", lows); end
   endtask

   task automatic test_disable;
      bit ok1, ok2;
      logic [31:0] d;
      wait_status(32'h10, ok1);
      wait_status(32'h20, ok2);
      total++;
      if (!(ok1 && ok2)) begin bad++; $display("FAIL disable wait guard: status=%h want 20", bus.readdata); end
      bus_write(2'd0, 32'h70);
      @(negedge clk);
      bus_read(2'd3, d); total++;
      if (d !== 32'h0) begin bad++; $display("FAIL disable status: %h want 0", d); end
      @(negedge clk);
      total++;
      if ({seg_n, dp_n, dig_n} !== {7'h7F, 1'b1, 8'hFF}) begin
         bad++; $display("FAIL disable outputs: seg=%h dp=%b dig=%h want 7f 1 ff", seg_n, dp_n, dig_n);
      end
   endtask

   task automatic test_reset_mid;
      bit ok;
      logic [31:0] d;
      bus_write(2'd0, 32'h0273);
      wait_dig(8'hFE, ok);
      total++;
      if (!ok) begin bad++; $display("FAIL remid wait drive: dig=%h want fe", dig_n); end
      #2 reset_n = 1'b0;
      #1;
      total++;
      if ({seg_n, dp_n, dig_n} !== {7'h7F, 1'b1, 8'hFF}) begin
         bad++; $display("FAIL async reset outputs: seg=%h dp=%b dig=%h want 7f 1 ff", seg_n, dp_n, dig_n);
      end
      bus_read(2'd0, d); total++;
      if (d !== 32'h71) begin bad++; $display("FAIL async reset ctrl: %h want 71", d); end
      @(negedge clk);
      reset_n = 1'b1;
   endtask

   initial begin
      test_reset;
      test_period;
      test_regs;
      test_lzb;
      test_snapshot;
      test_last_dp;
      test_pwm;
      test_disable;
      test_reset_mid;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/seven_seg_scanner.md
# seven_seg_scanner

Multiplexed seven-segment scan controller that sits between the seven-segment PIO's 32-bit output word and the board's common-anode display. It treats the word as eight hex nibbles and time-multiplexes them onto shared active-low segment lines with one-hot active-low digit enables. Scanning includes a ghosting guard interval, PWM brightness and leading-zero blanking. It is configured over an Avalon-MM slave with zero-wait-state reads, on the same bus as the PIO.

## Interface
- DEFAULT_DIV, 16'd49999: reset value of DIV; dwell is DIV+1 clocks (1 ms at 50 MHz).
- GUARD_CYC, 2: all-digits-off clocks between digits; legal range 1..15.
- clk  in  1  system clock; one clock domain.
- reset_n  in  1  asynchronous, active-low reset.
- address  in  2  register select.
- chipselect  in  1  slave select.
- write_n  in  1  active-low write strobe.
- writedata  in  32  write data.
- readdata  out  32  combinational read mux of the register at `address`; no wait states.
- data_in  in  32  display word; nibble i (bits 4i+3:4i) drives digit i, with digit 0 rightmost.
- seg_n  out  7  segments {g,f,e,d,c,b,a}, active-low, registered.
- dp_n  out  1  decimal point, active-low, registered.
- dig_n  out  8  digit enables, active-low, registered; at most one bit is low.

## Operation
- **Registers** (a write occurs when chipselect is high and write_n is low; a register takes its new value on the next clock edge):
  - 0 CTRL:
    - bit0 EN.
    - bit1 LZB (leading-zero blank).
    - bits[6:4] LAST, the highest digit index scanned.
    - bits[15:8] DPMASK.
    - Other bits read 0.
    - Reset value 0x00000071.
  - 1 DIV: bits[15:0]; reset value DEFAULT_DIV.
  - 2 DUTY: bits[3:0]; reset value 0xF.
  - 3 STATUS (read-only; writes ignored): bits[2:0] = idx, bits[5:4] = state code (OFF=0, DRIVE=1, GUARD=2).
- **State machine** (dwell counter `cnt`, digit index `idx`, 32-bit `shadow`):
  - OFF: all outputs are 1. When EN=1: `shadow` <= data_in, `idx` <= 0, `cnt` <= 0, then go to DRIVE.
  - DRIVE: drive digit `idx` and increment `cnt`. When `cnt` == DIV: `cnt` <= 0, go to GUARD.
  - GUARD: dig_n = 8'hFF for GUARD_CYC clocks. Then:
    - If `idx` >= LAST: `idx` <= 0 and `shadow` <= data_in (frame-boundary snapshot, so a frame never tears).
    - Otherwise `idx` <= `idx`+1.
    - Go to DRIVE.
  - EN=0 observed in any state: go to OFF on the next edge with all outputs 1. `idx` is cleared on the next enable.
- **Brightness**: a free-running 4-bit `pwm` counter, reset to 0. In DRIVE, dig_n[idx] = 0 only when `pwm` <= DUTY. DUTY=15 is always on; DUTY=0 is 1/16 duty.
- **Decode**: seg_n is the standard hex decode of shadow nibble `idx`:
  - 0=0x40, 1=0x79, 2=0x24, 3=0x30, 4=0x19, 5=0x12, 6=0x02, 7=0x78
  - 8=0x00, 9=0x10, A=0x08, b=0x03, C=0x46, d=0x21, E=0x06, F=0x0E
- **Decimal point**: dp_n = ~DPMASK[idx].
- **Leading-zero blanking**: when LZB=1 and idx > 0 and every shadow nibble from idx through LAST is 0, seg_n = 7'h7F and dp_n follows DPMASK. Digit 0 is never blanked.
- **Register changes mid-scan**:
  - A DIV write takes effect at the next comparison; if the new DIV is below `cnt`, DRIVE runs to a 16-bit wrap, and this is accepted.
  - A LAST write below the current `idx` wraps `idx` at the next GUARD exit.

## Timing
- **Reset values**: seg_n = 7'h7F, dp_n = 1, dig_n = 8'hFF, and state is OFF. EN resets to 1, so DRIVE is entered on the first edge after reset release and digit 0 is driven on the second.
- **Output registration**: outputs are registered, so they lag state/idx by one clock. All outputs change on the same edge, which means no segment change is visible while a digit is enabled.
- **Periods**: digit period = DIV+1+GUARD_CYC clocks. Frame period = (LAST+1) × digit period.
- **CTRL.EN=0 write**: dig_n = 8'hFF two edges after the write edge.
- **Read latency**: 0 cycles. readdata updates combinationally with address, and a read of a just-written register returns the new value on the following cycle.

## Test plan
- **Reset, defaults and period**: reset, DIV=3, GUARD_CYC=2, data_in=0x01234567 -> dig_n cycles FE,FF,FD,FF,...,7F with 4-clock active and 2-clock guard phases. Digit 0 shows seg_n=0x78 ('7') and digit 7 shows 0x40 ('0'). Frame = 48 clocks.
- **Leading-zero blanking**: LZB=1, data_in=0x000000A0 -> digit 0 seg_n=0x40, digit 1 0x08, digits 2..7 0x7F. Then data_in=0 -> digit 0 still 0x40.
- **Frame snapshot**: change data_in mid-frame (while idx=3) -> digits 4..7 keep the old values until idx wraps to 0.
- **PWM brightness**: DUTY=0 -> within DRIVE, the dig_n active bit is low 1 of every 16 clocks. DUTY=15 -> it is continuously low.
- **LAST reduction and DP**: LAST=3 written while idx=6 -> next digit driven is 0, and the scan visits only digits 0..3 thereafter. DPMASK=0x04 -> dp_n=0 only on digit 2.
- **Disable and reset mid-scan**: EN=0 during GUARD -> OFF, all outputs 1, STATUS=0x00. reset_n asserted mid-DRIVE -> outputs go to their reset values asynchronously, and CTRL reads 0x71.
